shared_buffer_allocator: RTL and testbench
==========================================

Name: shared_buffer_allocator

Overview:
- Per-input-port slot allocator for the DynVC shared memory bank. It arbitrates per-VC slot requests round-robin and drives the free_buffer_tracker pop/push interface.
- Enforces a guaranteed minimum (reserved) and a maximum occupancy per VC. This stops one VC from starving the others of the shared pool.
- Sits between the VC input logic and free_buffer_tracker. Returns one granted slot address per cycle.

Parameters:
- num_vcs, 4, number of requesting VCs
- memory_bank_depth, 32, slots in the shared bank; must be ≥ num_vcs*reserved_per_vc
- reserved_per_vc, 2, slots guaranteed to each VC
- max_per_vc, 16, occupancy cap per VC; must be ≥ reserved_per_vc
- Derived widths: addr_width=clogb(memory_bank_depth), vc_idx_width=clogb(num_vcs), cnt_width=clogb(memory_bank_depth+1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- alloc_req  in  num_vcs  per-VC slot request, level
- alloc_gnt  out  num_vcs  one-hot grant, valid one cycle
- alloc_slot  out  addr_width  slot address for alloc_gnt
- free_valid  in  1  one slot released this cycle
- free_vc  in  vc_idx_width  owner VC of the released slot
- free_slot  in  addr_width  released slot address
- vc_can_alloc  out  num_vcs  VC is currently eligible
- trk_read_enable  out  1  pop to tracker
- trk_next_available_slot  in  addr_width  tracker head
- trk_memory_bank_empty  in  1  tracker has no free slot
- trk_write_enable  out  1  push to tracker
- trk_new_freed_slot  out  addr_width  slot pushed to tracker
- alloc_error  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset is synchronous: reset==0 at a rising edge clears state.
  - occ[v]=0 for every VC; free_count=memory_bank_depth; rr_ptr=0.
  - alloc_gnt=0, alloc_slot=0, alloc_error=0.
  - The tracker shares the same reset and holds all slots after it.
- Shared pool: res_out = sum over v of max(reserved_per_vc-occ[v],0); shared_avail = free_count-res_out, never negative.
- vc_can_alloc[v]=1 iff all of:
  - occ[v]<max_per_vc;
  - free_count>0;
  - trk_memory_bank_empty==0;
  - occ[v]<reserved_per_vc OR shared_avail>0.
- Arbitration, cycle t:
  - Candidates = alloc_req & vc_can_alloc.
  - Winner = first candidate at or after rr_ptr, wrapping at num_vcs.
  - trk_read_enable=1 combinationally in cycle t if a winner exists.
- Grant at edge t→t+1:
  - alloc_gnt gets the winner one-hot; alloc_slot captures trk_next_available_slot.
  - occ[winner]+1; free_count-1; rr_ptr=(winner+1) mod num_vcs.
  - No winner: alloc_gnt=0, alloc_slot holds its value, rr_ptr unchanged.
- Latency: request at t gives grant at t+1. At most one grant per cycle. A requester whose alloc_req stays high is re-arbitrated every cycle.
- Free path, cycle t:
  - free_valid=1 drives trk_write_enable=1 and trk_new_freed_slot=free_slot combinationally.
  - At the edge: occ[free_vc]-1, free_count+1.
- Alloc and free in the same cycle:
  - Both take effect; free_count is net unchanged.
  - If free_vc equals the winner, that VC's occ is net unchanged.
  - Eligibility in cycle t uses pre-update values; a freed slot is usable from t+1.
- free_count and occ[] saturate: never wrap below 0 or above memory_bank_depth / max_per_vc.
- Reset low mid-operation: the next edge clears all state. alloc_gnt is 0 in the following cycle.

Optional Feature:
- Macro SHARED_BUFFER_ALLOC_ERR_CHECK_EN.
- Defined:
  - A free with occ[free_vc]==0, or with free_count==memory_bank_depth, is illegal.
  - An illegal free is dropped: trk_write_enable=0 and counters unchanged.
  - It sets alloc_error=1 at the next edge; alloc_error stays 1 until reset.
- Undefined: no check. Every free is forwarded and counted with saturation. alloc_error is tied to 0.

Test Plan:
- Reset, then alloc_req=4'b1111 held → grants VC0,1,2,3,0,1… one per cycle from the cycle after the first request; alloc_slot matches tracker head.
- Only VC0 requests, no frees → exactly 16 grants, then vc_can_alloc[0]=0, alloc_gnt=0, free_count=16.
- Continue: VC1 requests only → 12 grants (2 reserved + 10 shared), then blocked with free_count=4. VC2 and VC3 each still get exactly 2 grants; after that free_count=0.
- VC1 at occ=5 requests while free_valid=1, free_vc=1 in the same cycle → occ[1] stays 5, free_count unchanged, trk_read_enable=trk_write_enable=1.
- Reset driven low for one cycle while VC2 and VC3 request with grants in flight → alloc_gnt=0 next cycle, free_count=32, first grant after release goes to VC2 (rr_ptr=0, VC0/VC1 idle).
- With SHARED_BUFFER_ALLOC_ERR_CHECK_EN: free_valid=1, free_vc=3 with occ[3]=0 → trk_write_enable=0, alloc_error=1 sticky until reset. Without the macro: free is forwarded and alloc_error stays 0.

Source files
------------

// File: rtl/shared_buffer_allocator.sv
// shared_buffer_allocator: round-robin per-VC slot allocator with reserved/max occupancy over a shared bank.
// Optional macro SHARED_BUFFER_ALLOC_ERR_CHECK_EN drops illegal frees and raises a sticky alloc_error.
module shared_buffer_allocator #(
    parameter int num_vcs = 4,
    parameter int memory_bank_depth = 32,
    parameter int reserved_per_vc = 2,
    parameter int max_per_vc = 16,
    localparam int addr_width = $clog2(memory_bank_depth),
    localparam int vc_idx_width = (num_vcs > 1) ? $clog2(num_vcs) : 1,
    localparam int cnt_width = $clog2(memory_bank_depth + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [num_vcs-1:0]      alloc_req,
    output logic [num_vcs-1:0]      alloc_gnt,
    output logic [addr_width-1:0]   alloc_slot,
    input  logic                    free_valid,
    input  logic [vc_idx_width-1:0] free_vc,
    input  logic [addr_width-1:0]   free_slot,
    output logic [num_vcs-1:0]      vc_can_alloc,
    output logic                    trk_read_enable,
    input  logic [addr_width-1:0]   trk_next_available_slot,
    input  logic                    trk_memory_bank_empty,
    output logic                    trk_write_enable,
    output logic [addr_width-1:0]   trk_new_freed_slot,
    output logic                    alloc_error
);
    localparam logic [cnt_width-1:0] res_c = cnt_width'(reserved_per_vc);
    localparam logic [cnt_width-1:0] max_c = cnt_width'(max_per_vc);
    localparam logic [cnt_width-1:0] depth_c = cnt_width'(memory_bank_depth);
    localparam logic [cnt_width-1:0] one_c = cnt_width'(1);

    logic [cnt_width-1:0]    occ_q [num_vcs];
    logic [cnt_width-1:0]    occ_d [num_vcs];
    logic [cnt_width-1:0]    free_count_q, free_count_d, res_out;
    logic [vc_idx_width-1:0] rr_ptr_q, rr_ptr_d, win_vc;
    logic [num_vcs-1:0]      alloc_gnt_q, alloc_gnt_d, cand, inc_v, dec_v;
    logic [addr_width-1:0]   alloc_slot_q, alloc_slot_d;
    logic                    win, free_ok, free_illegal;

    // Slots still owed to VCs below their reservation are not lendable to others.
    always_comb begin
        res_out = '0;
        vc_can_alloc = '0;
        for (int v = 0; v < num_vcs; v++)
            res_out = res_out + ((occ_q[v] < res_c) ? res_c - occ_q[v] : '0);
        for (int v = 0; v < num_vcs; v++)
            vc_can_alloc[v] = (occ_q[v] < max_c) && (free_count_q != '0) && !trk_memory_bank_empty
                              && ((occ_q[v] < res_c) || (free_count_q > res_out));
    end

    // Scan downward so the last hit is the first candidate at or after rr_ptr.
    always_comb begin
        cand = alloc_req & vc_can_alloc;
        win = 1'b0;
        win_vc = rr_ptr_q;
        for (int i = num_vcs - 1; i >= 0; i--)
            if (cand[(int'(rr_ptr_q) + i) % num_vcs]) begin
                win = 1'b1;
                win_vc = vc_idx_width'((int'(rr_ptr_q) + i) % num_vcs);
            end
    end

`ifdef SHARED_BUFFER_ALLOC_ERR_CHECK_EN
    logic alloc_error_q;
    assign free_illegal = free_valid && ((occ_q[free_vc] == '0) || (free_count_q == depth_c));
    assign alloc_error = alloc_error_q;
    always_ff @(posedge clk) begin
        if (!reset)
            alloc_error_q <= 1'b0;
        else
            alloc_error_q <= alloc_error_q | free_illegal;
    end
`else
    assign free_illegal = 1'b0;
    assign alloc_error = 1'b0;
`endif

    assign free_ok = free_valid && !free_illegal;
    assign trk_read_enable = win;
    assign trk_write_enable = free_ok;
    assign trk_new_freed_slot = free_slot;
    assign alloc_gnt = alloc_gnt_q;
    assign alloc_slot = alloc_slot_q;

    always_comb begin
        inc_v = win ? (num_vcs'(1) << win_vc) : '0;
        dec_v = free_ok ? (num_vcs'(1) << free_vc) : '0;
        for (int v = 0; v < num_vcs; v++)
            occ_d[v] = (inc_v[v] && !dec_v[v] && occ_q[v] < max_c) ? occ_q[v] + one_c :
                       (dec_v[v] && !inc_v[v] && occ_q[v] != '0) ? occ_q[v] - one_c : occ_q[v];
        free_count_d = (win && !free_ok && free_count_q != '0) ? free_count_q - one_c :
                       (free_ok && !win && free_count_q != depth_c) ? free_count_q + one_c : free_count_q;
        rr_ptr_d = !win ? rr_ptr_q :
                   (win_vc == vc_idx_width'(num_vcs - 1)) ? '0 : win_vc + vc_idx_width'(1);
        alloc_gnt_d = inc_v;
        alloc_slot_d = win ? trk_next_available_slot : alloc_slot_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int v = 0; v < num_vcs; v++)
                occ_q[v] <= '0;
            free_count_q <= depth_c;
            rr_ptr_q <= '0;
            alloc_gnt_q <= '0;
            alloc_slot_q <= '0;
        end else begin
            for (int v = 0; v < num_vcs; v++)
                occ_q[v] <= occ_d[v];
            free_count_q <= free_count_d;
            rr_ptr_q <= rr_ptr_d;
            alloc_gnt_q <= alloc_gnt_d;
            alloc_slot_q <= alloc_slot_d;
        end
    end
endmodule

// File: tb/tb_shared_buffer_allocator.sv
// tb_shared_buffer_allocator: directed bench for shared_buffer_allocator with a counting tracker model.
module tb_shared_buffer_allocator;
`ifdef SHARED_BUFFER_ALLOC_ERR_CHECK_EN
    localparam bit err_en = 1'b1;
`else
    localparam bit err_en = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] alloc_req = '0;
    logic [3:0] alloc_gnt, vc_can_alloc;
    logic [4:0] alloc_slot, trk_new_freed_slot;
    logic [4:0] trk_next_available_slot = '0;
    logic [4:0] free_slot = '0;
    logic       free_valid = 1'b0;
    logic [1:0] free_vc = '0;
    logic       trk_read_enable, trk_write_enable, alloc_error;
    logic       trk_memory_bank_empty = 1'b0;
    logic [3:0] exp_gnt;
    int total = 0;
    int bad = 0;
    int n0, n1;

    shared_buffer_allocator dut (
        .clk(clk),
        .reset(reset),
        .alloc_req(alloc_req),
        .alloc_gnt(alloc_gnt),
        .alloc_slot(alloc_slot),
        .free_valid(free_valid),
        .free_vc(free_vc),
        .free_slot(free_slot),
        .vc_can_alloc(vc_can_alloc),
        .trk_read_enable(trk_read_enable),
        .trk_next_available_slot(trk_next_available_slot),
        .trk_memory_bank_empty(trk_memory_bank_empty),
        .trk_write_enable(trk_write_enable),
        .trk_new_freed_slot(trk_new_freed_slot),
        .alloc_error(alloc_error)
    );

    always #5 clk = ~clk;

    // Tracker model: head advances on each pop, returns to slot 0 on reset.
    task automatic tick;
        logic re;
        #1;
        re = trk_read_enable;
        @(posedge clk);
        #1;
        if (!reset) trk_next_available_slot = '0;
        else if (re) trk_next_available_slot = trk_next_available_slot + 5'd1;
    endtask

    task automatic apply_reset;
        reset = 1'b0;
        alloc_req = '0;
        free_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick();
        tick();
        total++; if (alloc_gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", alloc_gnt); end
        total++; if (alloc_slot !== 5'd0) begin bad++; $display("FAIL reset_slot got=%0d exp=0", alloc_slot); end
        total++; if (alloc_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", alloc_error); end
        reset = 1'b1;
        #1;
        total++; if (vc_can_alloc !== 4'b1111) begin bad++; $display("FAIL reset_can got=%b exp=1111", vc_can_alloc); end
        total++; if (trk_read_enable !== 1'b0) begin bad++; $display("FAIL reset_re got=%b exp=0", trk_read_enable); end
        total++; if (dut.free_count_q !== 6'd32) begin bad++; $display("FAIL reset_free got=%0d exp=32", dut.free_count_q); end
    endtask

    task automatic test_round_robin;
        alloc_req = 4'b1111;
        #1;
        total++; if (trk_read_enable !== 1'b1) begin bad++; $display("FAIL rr_re got=%b exp=1", trk_read_enable); end
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_gnt = 4'(1 << (k % 4));
            total++; if (alloc_gnt !== exp_gnt) begin bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, alloc_gnt, exp_gnt); end
            total++; if (alloc_slot !== 5'(k)) begin bad++; $display("FAIL rr_slot%0d got=%0d exp=%0d", k, alloc_slot, k); end
        end
        alloc_req = '0;
        tick();
        total++; if (alloc_gnt !== 4'b0) begin bad++; $display("FAIL rr_idle_gnt got=%b exp=0000", alloc_gnt); end
        total++; if (alloc_slot !== 5'd5) begin bad++; $display("FAIL rr_hold_slot got=%0d exp=5", alloc_slot); end
    endtask

    task automatic test_vc_limits;
        apply_reset();
        alloc_req = 4'b0001;
        n0 = 0;
        repeat (20) begin tick(); if (alloc_gnt == 4'b0001) n0++; end
        total++; if (n0 != 16) begin bad++; $display("FAIL cap_vc0_grants got=%0d exp=16", n0); end
        total++; if (alloc_gnt !== 4'b0) begin bad++; $display("FAIL cap_vc0_gnt got=%b exp=0000", alloc_gnt); end
        total++; if (vc_can_alloc !== 4'b1110) begin bad++; $display("FAIL cap_vc0_can got=%b exp=1110", vc_can_alloc); end
        total++; if (dut.free_count_q !== 6'd16) begin bad++; $display("FAIL cap_vc0_free got=%0d exp=16", dut.free_count_q); end
        alloc_req = 4'b0010;
        n0 = 0;
        repeat (16) begin tick(); if (alloc_gnt == 4'b0010) n0++; end
        total++; if (n0 != 12) begin bad++; $display("FAIL shared_vc1_grants got=%0d exp=12", n0); end
        total++; if (vc_can_alloc !== 4'b1100) begin bad++; $display("FAIL shared_vc1_can got=%b exp=1100", vc_can_alloc); end
        total++; if (dut.free_count_q !== 6'd4) begin bad++; $display("FAIL shared_vc1_free got=%0d exp=4", dut.free_count_q); end
        alloc_req = 4'b1100;
        n0 = 0;
        n1 = 0;
        repeat (8) begin
            tick();
            if (alloc_gnt == 4'b0100) n0++;
            if (alloc_gnt == 4'b1000) n1++;
        end
        total++; if (n0 != 2) begin bad++; $display("FAIL reserved_vc2 got=%0d exp=2", n0); end
        total++; if (n1 != 2) begin bad++; $display("FAIL reserved_vc3 got=%0d exp=2", n1); end
        total++; if (dut.free_count_q !== 6'd0) begin bad++; $display("FAIL drained_free got=%0d exp=0", dut.free_count_q); end
        total++; if (vc_can_alloc !== 4'b0000) begin bad++; $display("FAIL drained_can got=%b exp=0000", vc_can_alloc); end
        alloc_req = '0;
    endtask

    task automatic test_same_cycle;
        apply_reset();
        alloc_req = 4'b0010;
        repeat (5) tick();
        free_valid = 1'b1;
        free_vc = 2'd1;
        free_slot = 5'd7;
        #1;
        total++; if (trk_read_enable !== 1'b1) begin bad++; $display("FAIL both_re got=%b exp=1", trk_read_enable); end
        total++; if (trk_write_enable !== 1'b1) begin bad++; $display("FAIL both_we got=%b exp=1", trk_write_enable); end
        total++; if (trk_new_freed_slot !== 5'd7) begin bad++; $display("FAIL both_slot got=%0d exp=7", trk_new_freed_slot); end
        tick();
        total++; if (alloc_gnt !== 4'b0010) begin bad++; $display("FAIL both_gnt got=%b exp=0010", alloc_gnt); end
        total++; if (dut.occ_q[1] !== 6'd5) begin bad++; $display("FAIL both_occ got=%0d exp=5", dut.occ_q[1]); end
        total++; if (dut.free_count_q !== 6'd27) begin bad++; $display("FAIL both_free got=%0d exp=27", dut.free_count_q); end
        alloc_req = '0;
        tick();
        total++; if (dut.occ_q[1] !== 6'd4) begin bad++; $display("FAIL free_occ got=%0d exp=4", dut.occ_q[1]); end
        total++; if (dut.free_count_q !== 6'd28) begin bad++; $display("FAIL free_free got=%0d exp=28", dut.free_count_q); end
        free_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        apply_reset();
        alloc_req = 4'b1100;
        tick();
        total++; if (alloc_gnt !== 4'b0100) begin bad++; $display("FAIL mid_first_gnt got=%b exp=0100", alloc_gnt); end
        reset = 1'b0;
        tick();
        total++; if (alloc_gnt !== 4'b0) begin bad++; $display("FAIL mid_rst_gnt got=%b exp=0000", alloc_gnt); end
        total++; if (dut.free_count_q !== 6'd32) begin bad++; $display("FAIL mid_rst_free got=%0d exp=32", dut.free_count_q); end
        reset = 1'b1;
        tick();
        total++; if (alloc_gnt !== 4'b0100) begin bad++; $display("FAIL mid_rel_gnt got=%b exp=0100", alloc_gnt); end
        total++; if (alloc_slot !== 5'd0) begin bad++; $display("FAIL mid_rel_slot got=%0d exp=0", alloc_slot); end
        alloc_req = '0;
        tick();
    endtask

    task automatic test_illegal_free;
        apply_reset();
        free_valid = 1'b1;
        free_vc = 2'd3;
        free_slot = 5'd9;
        #1;
        total++; if (trk_write_enable !== !err_en) begin bad++; $display("FAIL bad_free_we got=%b exp=%b", trk_write_enable, !err_en); end
        tick();
        free_valid = 1'b0;
        total++; if (alloc_error !== err_en) begin bad++; $display("FAIL bad_free_err got=%b exp=%b", alloc_error, err_en); end
        total++; if (dut.free_count_q !== 6'd32) begin bad++; $display("FAIL bad_free_sat got=%0d exp=32", dut.free_count_q); end
        tick();
        total++; if (alloc_error !== err_en) begin bad++; $display("FAIL bad_free_sticky got=%b exp=%b", alloc_error, err_en); end
        apply_reset();
        total++; if (alloc_error !== 1'b0) begin bad++; $display("FAIL bad_free_clr got=%b exp=0", alloc_error); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_vc_limits();
        test_same_cycle();
        test_reset_mid();
        test_illegal_free();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
